// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared opcodes, fetch FSM encoding and reset PC for the fetch stage
package fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - jump/branch/sequential target select with misalignment detect
module fetch_unit_next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_br_offset,
  input  logic [25:0]       i_jmp_index,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_misalign
);

  logic [ADDR_W-1:0] w_jmp_target;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_raw_target;

  assign w_jmp_target = {i_pc_plus4[ADDR_W-1:28], i_jmp_index, 2'b00};
  assign w_br_target  = i_pc_plus4 + (i_br_offset << 2);

  // Jump outranks a taken bne when decode asserts both.
  always_comb begin
    w_raw_target = i_pc_plus4;
    if (i_jump) begin
      w_raw_target = w_jmp_target;
    end else if (i_branch && !i_zero) begin
      w_raw_target = w_br_target;
    end
  end

  assign o_misalign = |w_raw_target[1:0];
  assign o_next_pc  = {w_raw_target[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage feeding decode/control
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [31:0]       i_imem_rdata,
  output logic [31:0]       o_instr,
  output logic [5:0]        o_opcode,
  output logic              o_instr_valid,
  input  logic              i_instr_accept,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_br_offset,
  input  logic [25:0]       i_jmp_index,
  output logic              o_misalign,
  output logic [31:0]       o_retired
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic              r_misalign;
  logic [31:0]       r_retired;

  logic              w_capture;
  logic              w_retire;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_target_misalign;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_imem_req   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_instr_accept) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Ready/accept only count in the state that owns them, so stray pulses are ignored.
  assign w_capture  = (r_state == FETCH) && i_imem_ready;
  assign w_retire   = (r_state == HOLD) && i_instr_accept;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  fetch_unit_next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .i_pc_plus4  (w_pc_plus4),
    .i_branch    (i_branch),
    .i_jump      (i_jump),
    .i_zero      (i_zero),
    .i_br_offset (i_br_offset),
    .i_jmp_index (i_jmp_index),
    .o_next_pc   (w_next_pc),
    .o_misalign  (w_target_misalign)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_retired  <= 32'h0;
    end else begin
      if (w_capture) begin
        r_instr <= i_imem_rdata;
        r_valid <= 1'b1;
      end
      if (w_retire) begin
        r_valid    <= 1'b0;
        r_retired  <= r_retired + 32'd1;
        r_pc       <= w_next_pc;
        r_misalign <= r_misalign | w_target_misalign;
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[31:26];
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_misalign    = r_misalign;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table plus hand sequences for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_accept;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] br_offset;
  logic [25:0] jmp_index;

  logic        req_a, valid_a, mis_a;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a, ret_a;
  logic [5:0]  opc_a;

  logic        req_b, valid_b, mis_b;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b, ret_b;
  logic [5:0]  opc_b;

  int errors = 0;
  int checks = 0;

  fetch_unit u_dut_a (
    .i_clk          (clk),
    .i_reset        (reset),
    .o_imem_req     (req_a),
    .o_imem_addr    (addr_a),
    .i_imem_ready   (imem_ready),
    .i_imem_rdata   (imem_rdata),
    .o_instr        (instr_a),
    .o_opcode       (opc_a),
    .o_instr_valid  (valid_a),
    .i_instr_accept (instr_accept),
    .o_pc           (pc_a),
    .o_pc_plus4     (pc4_a),
    .i_branch       (branch),
    .i_jump         (jump),
    .i_zero         (zero),
    .i_br_offset    (br_offset),
    .i_jmp_index    (jmp_index),
    .o_misalign     (mis_a),
    .o_retired      (ret_a)
  );

  // Misaligned reset PC is the only way a redirect target can have nonzero low bits.
  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0002)) u_dut_b (
    .i_clk          (clk),
    .i_reset        (reset),
    .o_imem_req     (req_b),
    .o_imem_addr    (addr_b),
    .i_imem_ready   (imem_ready),
    .i_imem_rdata   (imem_rdata),
    .o_instr        (instr_b),
    .o_opcode       (opc_b),
    .o_instr_valid  (valid_b),
    .i_instr_accept (instr_accept),
    .o_pc           (pc_b),
    .o_pc_plus4     (pc4_b),
    .i_branch       (branch),
    .i_jump         (jump),
    .i_zero         (zero),
    .i_br_offset    (br_offset),
    .i_jmp_index    (jmp_index),
    .o_misalign     (mis_b),
    .o_retired      (ret_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        accept;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] off;
    logic [25:0] idx;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_ret;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] last_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture row: accept/branch/jump asserted on purpose, they must be ignored in FETCH.
  task automatic cap(input logic [31:0] rd, input logic [31:0] pc, input logic [31:0] ret);
    vec_t v;
    v = '{ready: 1'b1, rdata: rd, accept: 1'b1, branch: 1'b1, jump: 1'b1, zero: 1'b0,
          off: 32'h0000_0040, idx: 26'h3FF_FFFF, e_req: 1'b0, e_valid: 1'b1,
          e_instr: rd, e_pc: pc, e_ret: ret};
    last_rd = rd;
    vecs.push_back(v);
  endtask

  // Accept row: ready asserted with junk data, it must be ignored in HOLD.
  task automatic acc(input logic br, input logic jp, input logic zr, input logic [31:0] off,
                     input logic [25:0] idx, input logic [31:0] pc, input logic [31:0] ret);
    vec_t v;
    v = '{ready: 1'b1, rdata: 32'hDEAD_BEEF, accept: 1'b1, branch: br, jump: jp, zero: zr,
          off: off, idx: idx, e_req: 1'b1, e_valid: 1'b0,
          e_instr: last_rd, e_pc: pc, e_ret: ret};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    instr_accept = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    zero         = 1'b0;
    br_offset    = 32'h0;
    jmp_index    = 26'h0;
  endtask

  initial begin
    logic [31:0] held_instr;

    reset = 1'b1;
    idle_inputs();
    tick();
    tick();

    chk("rst_req",    {31'b0, req_a},   32'h0);
    chk("rst_valid",  {31'b0, valid_a}, 32'h0);
    chk("rst_pc",     pc_a,             32'h0);
    chk("rst_instr",  instr_a,          32'h0);
    chk("rst_ret",    ret_a,            32'h0);
    chk("rst_mis",    {31'b0, mis_a},   32'h0);
    chk("rst_pc_b",   pc_b,             32'h0000_0002);

    reset = 1'b0;
    #1;
    chk("req_1st_cycle", {31'b0, req_a}, 32'h0);
    tick();
    chk("req_2nd_cycle", {31'b0, req_a}, 32'h1);
    chk("addr_start",    addr_a,         32'h0);

    cap(32'h8C01_0004, 32'h0000_0000, 0);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_0004, 1);
    cap(32'h8C01_0004, 32'h0000_0004, 1);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_0008, 2);
    cap(32'h8C01_0004, 32'h0000_0008, 2);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_000C, 3);
    cap(32'hAC02_0008, 32'h0000_000C, 3);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_0010, 4);
    cap(32'h1422_FFFE, 32'h0000_0010, 4);
    acc(1, 0, 0, 32'hFFFF_FFFE, 26'h0,  32'h0000_000C, 5);
    cap(32'h0000_0020, 32'h0000_000C, 5);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_0010, 6);
    cap(32'h1422_FFFE, 32'h0000_0010, 6);
    acc(1, 0, 1, 32'hFFFF_FFFE, 26'h0,  32'h0000_0014, 7);
    cap(32'h1400_0000, 32'h0000_0014, 7);
    acc(1, 0, 0, 32'h03FF_FFFA, 26'h0,  32'h1000_0000, 8);
    cap(32'h0800_0040, 32'h1000_0000, 8);
    acc(0, 1, 0, 32'h0,         26'h40, 32'h1000_0100, 9);
    cap(32'h0800_0040, 32'h1000_0100, 9);
    acc(1, 1, 0, 32'h0000_0005, 26'h40, 32'h1000_0100, 10);
    cap(32'h3821_1234, 32'h1000_0100, 10);
    acc(1, 0, 0, 32'h3BFF_FFBE, 26'h0,  32'hFFFF_FFFC, 11);
    cap(32'h8C01_0004, 32'hFFFF_FFFC, 11);
    acc(0, 0, 0, 32'h0,         26'h0,  32'h0000_0000, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      imem_ready   = vecs[i].ready;
      imem_rdata   = vecs[i].rdata;
      instr_accept = vecs[i].accept;
      branch       = vecs[i].branch;
      jump         = vecs[i].jump;
      zero         = vecs[i].zero;
      br_offset    = vecs[i].off;
      jmp_index    = vecs[i].idx;
      tick();
      chk($sformatf("v%0d_req", i),    {31'b0, req_a},   {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i),  {31'b0, valid_a}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i),  instr_a,          vecs[i].e_instr);
      chk($sformatf("v%0d_opcode", i), {26'b0, opc_a},   {26'b0, vecs[i].e_instr[31:26]});
      chk($sformatf("v%0d_pc", i),     pc_a,             vecs[i].e_pc);
      chk($sformatf("v%0d_addr", i),   addr_a,           vecs[i].e_pc);
      chk($sformatf("v%0d_pc4", i),    pc4_a,            vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d_ret", i),    ret_a,            vecs[i].e_ret);
    end

    // Memory stall in FETCH: request and address must hold for the whole wait.
    idle_inputs();
    instr_accept = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_req", i),   {31'b0, req_a},   32'h1);
      chk($sformatf("stall%0d_addr", i),  addr_a,           32'h0);
      chk($sformatf("stall%0d_valid", i), {31'b0, valid_a}, 32'h0);
    end
    imem_ready   = 1'b1;
    imem_rdata   = 32'h3821_1234;
    instr_accept = 1'b0;
    tick();
    chk("stall_cap_instr",  instr_a,        32'h3821_1234);
    chk("stall_cap_opcode", {26'b0, opc_a}, 32'h0000_000E);
    held_instr = 32'h3821_1234;

    // Consumer stall in HOLD: nothing moves and no new request.
    imem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_req", i),   {31'b0, req_a},   32'h0);
      chk($sformatf("hold%0d_instr", i), instr_a,          held_instr);
      chk($sformatf("hold%0d_pc", i),    pc_a,             32'h0);
      chk($sformatf("hold%0d_valid", i), {31'b0, valid_a}, 32'h1);
    end
    imem_ready   = 1'b0;
    instr_accept = 1'b1;
    tick();
    chk("hold_release_pc",  pc_a,  32'h0000_0004);
    chk("hold_release_ret", ret_a, 32'd13);

    // Reset mid-FETCH with a late ready the cycle after.
    instr_accept = 1'b0;
    reset        = 1'b1;
    tick();
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("midrst_valid", {31'b0, valid_a}, 32'h0);
    chk("midrst_instr", instr_a,          32'h0);
    chk("midrst_pc",    pc_a,             32'h0);
    chk("midrst_ret",   ret_a,            32'h0);
    chk("midrst_mis_b", {31'b0, mis_b},   32'h0);
    chk("midrst_req",   {31'b0, req_a},   32'h1);
    chk("midrst_addr",  addr_a,           32'h0);

    // Misalign: B starts at pc=2, so a taken bne with offset 0 targets 6.
    imem_rdata = 32'h1400_0000;
    tick();
    chk("mis_cap_instr_b", instr_b, 32'h1400_0000);
    imem_ready   = 1'b0;
    instr_accept = 1'b1;
    branch       = 1'b1;
    zero         = 1'b0;
    br_offset    = 32'h0;
    tick();
    chk("mis_set_b",     {31'b0, mis_b}, 32'h1);
    chk("mis_pc_b",      pc_b,           32'h0000_0004);
    chk("mis_addr_b",    addr_b,         32'h0000_0004);
    chk("mis_req_b",     {31'b0, req_b}, 32'h1);
    chk("mis_clear_a",   {31'b0, mis_a}, 32'h0);
    chk("mis_pc_a",      pc_a,           32'h0000_0004);
    idle_inputs();
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0020;
    tick();
    chk("mis_opc_b",   {26'b0, opc_b},    32'h0);
    chk("mis_valid_b", {31'b0, valid_b},  32'h1);
    imem_ready   = 1'b0;
    instr_accept = 1'b1;
    tick();
    chk("mis_sticky_b", {31'b0, mis_b}, 32'h1);
    chk("mis_pc2_b",    pc_b,           32'h0000_0008);
    chk("mis_pc4_b",    pc4_b,          32'h0000_000C);
    chk("mis_ret_b",    ret_b,          32'd2);
    instr_accept = 1'b0;
    reset        = 1'b1;
    tick();
    chk("mis_rst_b",    {31'b0, mis_b}, 32'h0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the Control decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Registers each returned instruction and presents it, with its opcode field, to decode and control.
- Computes the next PC from the branch/jump/zero feedback returned when the consumer accepts the instruction. This supports bne (branch when Zero=0) and j.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
- instr  out  32  registered instruction.
- opcode  out  6  instr[31:26], fed to Control.Opcode.
- instr_valid  out  1  instr/pc/opcode hold a live instruction.
- instr_accept  in  1  consumer retires the instruction this cycle.
- pc  out  ADDR_W  address of instr.
- pc_plus4  out  ADDR_W  pc + 4.
- branch  in  1  Control.Branch for the retiring instruction.
- jump  in  1  Control.Jump for the retiring instruction.
- zero  in  1  ALU zero for the retiring instruction.
- br_offset  in  ADDR_W  sign-extended 16-bit immediate.
- jmp_index  in  26  instr[25:0].
- misalign  out  1  sticky flag; a redirect target had bits[1:0] != 0.
- retired  out  32  count of accepted instructions.

Behaviour:
- Reset (sync, active-high): pc=RESET_PC; state=IDLE; instr=0; instr_valid=0; misalign=0; retired=0; imem_req=0. Reset overrides every other event in the same cycle.
- FSM states are IDLE, FETCH, HOLD. Only one request is ever outstanding.
- IDLE: entered only by reset. Moves to FETCH on the first cycle with reset low, so imem_req rises on the second cycle after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc. Address is stable until ready.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, state goes to HOLD.
  - No ready: stay, unbounded wait.
  - instr_accept is ignored in FETCH.
- HOLD:
  - imem_req=0. instr, pc and opcode are held constant.
  - On instr_accept: instr_valid<=0, retired<=retired+1 (wraps at 2^32), pc<=next_pc, state goes to FETCH.
- Latency: minimum 2 cycles per instruction (ready in the request cycle, accept in the first HOLD cycle). The fetch-to-valid latency is 1 cycle after the ready edge.
- next_pc, evaluated only at accept, first match wins:
  1. jump=1: {pc_plus4[31:28], jmp_index, 2'b00}.
  2. branch=1 and zero=0: pc_plus4 + (br_offset << 2), mod 2^ADDR_W.
  3. Otherwise: pc_plus4.
- When jump and branch are both set, jump wins.
- pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- misalign: set at accept if next_pc[1:0] != 0. The PC is still loaded with bits[1:0] forced to 00. Cleared only by reset.
- Reset mid-FETCH: the request is dropped at the reset edge. A late imem_ready is ignored because imem_req=0.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BNE=6'b000101, OP_XORI=6'b001110, OP_J=6'b000010;
  - fetch state encoding IDLE/FETCH/HOLD;
  - RESET_PC default.
- One natural sub-module: next_pc_calc, the combinational target/select logic plus misalign detection.

Test Plan:
- Reset, then imem_ready held 1 with rdata=32'h8C01_0004 and accept=1 in HOLD → imem_req rises on the 2nd cycle after reset falls; opcode=6'b100011; pc sequence 0, 4, 8; retired increments every 2 cycles.
- pc=32'h10, branch=1, zero=0, br_offset=32'hFFFF_FFFE at accept → next imem_addr=32'h0C. Repeat with zero=1 → 32'h14.
- pc=32'h1000_0000, jump=1, jmp_index=26'h000_0040 at accept → imem_addr=32'h1000_0100. With branch=1 and zero=0 also set → jump still wins.
- imem_ready low for 5 cycles in FETCH → imem_req stays 1 and imem_addr stable; instr_valid=0. Hold accept low for 3 cycles in HOLD → instr and pc unchanged, no new request.
- Assert reset for one cycle mid-FETCH with imem_ready=1 in the following cycle → no instruction is captured; pc=RESET_PC; retired=0; fetch restarts at 0.
- br_offset producing target 32'h0000_0006 → misalign=1; pc loaded as 32'h04; flag persists until reset.
